// File: rtl/alu_vector_sequencer.sv
// ---------------------------------------------------------------------------
// alu_vector_sequencer
//
// Runs one LANES-element vector instruction through a shared external
// combinational ALU, one element per clock, and returns the collected result
// vector over a valid/ready handshake.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   opValid/opReady   instruction handshake (accepted only in IDLE)
//   opFunction        function code (1..11 legal, 6/7 = move scalar)
//   opScalarMode      1: operand B is opScalar broadcast, 0: operand B is opVecB
//   opVecA, opVecB    operand vectors, lane i at [i*BITS +: BITS]
//   opScalar          scalar operand
//   aluFunction/A/B   drive the external ALU (all zero outside EXEC)
//   aluResult         combinational ALU result for the lane being driven
//   resValid/resReady result handshake
//   resVec, resError  result vector and illegal-code flag
//   busy              FSM not in IDLE
//   resZero           (only with ALU_VECTOR_SEQUENCER_ZERO_FLAG_EN) all lanes 0
//
// Optional feature macro: ALU_VECTOR_SEQUENCER_ZERO_FLAG_EN
//
// State | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for an instruction, opReady high
// EXEC  | one lane per cycle through the ALU, result written at the edge
// DONE  | resValid high, result held until the consumer accepts it
// ---------------------------------------------------------------------------
module alu_vector_sequencer #(
  parameter int BITS  = 8,
  parameter int LANES = 4,
  parameter int ALUOP = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   opValid,
  output logic                   opReady,
  input  logic [ALUOP-1:0]       opFunction,
  input  logic                   opScalarMode,
  input  logic [LANES*BITS-1:0]  opVecA,
  input  logic [LANES*BITS-1:0]  opVecB,
  input  logic [BITS-1:0]        opScalar,
  output logic [ALUOP-1:0]       aluFunction,
  output logic [BITS-1:0]        aluA,
  output logic [BITS-1:0]        aluB,
  input  logic [BITS-1:0]        aluResult,
  output logic                   resValid,
  input  logic                   resReady,
  output logic [LANES*BITS-1:0]  resVec,
  output logic                   resError,
  output logic                   busy
`ifdef ALU_VECTOR_SEQUENCER_ZERO_FLAG_EN
  ,
  output logic                   resZero
`endif
);

  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int VW = LANES * BITS;

  localparam logic [ALUOP-1:0] FN_FIRST = ALUOP'(1);
  localparam logic [ALUOP-1:0] FN_LAST  = ALUOP'(11);
  localparam logic [ALUOP-1:0] FN_MOV0  = ALUOP'(6);
  localparam logic [ALUOP-1:0] FN_MOV1  = ALUOP'(7);
  localparam logic [LW-1:0]    LANE_END = LW'(LANES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [ALUOP-1:0] r_func;
  logic             r_scalar_mode;
  logic [VW-1:0]    r_vec_a;
  logic [VW-1:0]    r_vec_b;
  logic [BITS-1:0]  r_scalar;
  logic [LW-1:0]    r_lane;
  logic [VW-1:0]    r_res_vec;
  logic             r_res_error;

  logic             w_accept;
  logic             w_legal;
  logic             w_move;
  logic             w_last;
  logic [BITS-1:0]  w_lane_a;
  logic [BITS-1:0]  w_lane_b;
  logic [BITS-1:0]  w_lane_res;

  assign w_accept = opValid && (r_state == S_IDLE);
  assign w_legal  = (opFunction >= FN_FIRST) && (opFunction <= FN_LAST);
  assign w_move   = (r_func == FN_MOV0) || (r_func == FN_MOV1);
  assign w_last   = (r_lane == LANE_END);

  assign w_lane_a   = r_vec_a[r_lane*BITS +: BITS];
  assign w_lane_b   = r_scalar_mode ? r_scalar : r_vec_b[r_lane*BITS +: BITS];
  // Move-scalar codes never use the ALU output, so the slot takes the scalar.
  assign w_lane_res = w_move ? r_scalar : aluResult;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and state-decoded outputs
  always_comb begin
    w_next      = r_state;
    opReady     = 1'b0;
    resValid    = 1'b0;
    busy        = 1'b1;
    aluFunction = '0;
    aluA        = '0;
    aluB        = '0;
    case (r_state)
      S_IDLE: begin
        opReady = 1'b1;
        busy    = 1'b0;
        if (opValid) begin
          // Illegal codes skip EXEC entirely; the ALU stays untouched.
          w_next = w_legal ? S_EXEC : S_DONE;
        end
      end
      S_EXEC: begin
        aluFunction = w_move ? '0 : r_func;
        aluA        = w_lane_a;
        aluB        = w_lane_b;
        if (w_last) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        resValid = 1'b1;
        if (resReady) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Operand capture, lane counter and result collection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_func        <= '0;
      r_scalar_mode <= 1'b0;
      r_vec_a       <= '0;
      r_vec_b       <= '0;
      r_scalar      <= '0;
      r_lane        <= '0;
      r_res_vec     <= '0;
      r_res_error   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_func        <= opFunction;
        r_scalar_mode <= opScalarMode;
        r_vec_a       <= opVecA;
        r_vec_b       <= opVecB;
        r_scalar      <= opScalar;
        r_lane        <= '0;
        r_res_vec     <= '0;
        r_res_error   <= !w_legal;
      end else if (r_state == S_EXEC) begin
        r_res_vec[r_lane*BITS +: BITS] <= w_lane_res;
        r_lane <= w_last ? '0 : r_lane + LW'(1);
      end
    end
  end

  assign resVec   = r_res_vec;
  assign resError = r_res_error;

`ifdef ALU_VECTOR_SEQUENCER_ZERO_FLAG_EN
  // Derived from the held result, so it is stable for the whole DONE window.
  assign resZero = (r_state == S_DONE) && !r_res_error && (r_res_vec == '0);
`endif

endmodule
